// File: rtl/pcm_frame_buffer.sv
// Ping-pong frame buffer between the CIC decimator and a back-pressured frame consumer.
// Whole frames are captured into one bank while the other bank streams out with valid/ready.
module pcm_frame_buffer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk_in,
  input  logic              switch_reset,
  input  logic [DATA_W-1:0] pcm_in,
  input  logic              pcm_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [15:0]       frames_done
);

  localparam logic [ADDR_W-1:0] IdxLast = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic {WFill, WWait} wstate_e;
  typedef enum logic {RIdle, RStream} rstate_e;

  // Simple dual-port storage, kept reset-free so it maps onto block RAM
  logic [DATA_W-1:0] mem [2*FRAME_LEN];
  logic [ADDR_W:0]   wr_addr, rd_addr;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= pcm_in;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // Writer state
  wstate_e           wstate_q, wstate_d;
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              drop;

  // Reader state
  rstate_e           rstate_q, rstate_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              rd_more_q, rd_more_d;
  logic [15:0]       frames_q, frames_d;
  logic              rd_bank;
  logic [ADDR_W-1:0] issue_idx;

  // Output pipeline: one read in flight, a skid word and the output word
  logic              inflight_q, inflight_d;
  logic              inflight_sof_q, inflight_sof_d, inflight_eof_q, inflight_eof_d;
  logic              skid_valid_q, skid_valid_d, skid_sof_q, skid_sof_d, skid_eof_q, skid_eof_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic       pop, rel_en, out_take, space;
  logic [1:0] rel_vec;
  logic [1:0] occ;

  assign pop     = out_valid_q & out_ready;
  assign rel_en  = pop & out_eof_q;
  assign rel_vec = rel_en ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    wstate_d = wstate_q;
    wbank_d  = wbank_q;
    widx_d   = widx_q;
    full_d   = full_q & ~rel_vec;
    wr_en    = 1'b0;
    drop     = 1'b0;
    wr_addr  = {wbank_q, widx_q};
    unique case (wstate_q)
      WFill: begin
        if (pcm_valid) begin
          wr_en = 1'b1;
          if (widx_q == IdxLast) begin
            full_d[wbank_q] = 1'b1;
            widx_d          = '0;
            if (!full_q[~wbank_q] || rel_vec[~wbank_q]) begin
              wbank_d = ~wbank_q;
            end else begin
              wstate_d = WWait;
            end
          end else begin
            widx_d = widx_q + ADDR_W'(1);
          end
        end
      end
      WWait: begin
        // A sample coincident with the release is still dropped; the next one starts the frame
        drop = pcm_valid;
        if (rel_vec[~wbank_q]) begin
          wbank_d  = ~wbank_q;
          widx_d   = '0;
          wstate_d = WFill;
        end
      end
      default: wstate_d = WFill;
    endcase
    overflow_d = (overflow_q & ~clr_overflow) | drop;
  end

  always_comb begin
    // Occupancy after this cycle's pop; issuing is safe while it stays below two
    occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, pop};
    space     = (occ < 2'd2);
    rstate_d  = rstate_q;
    rbank_d   = rbank_q;
    rd_idx_d  = rd_idx_q;
    rd_more_d = rd_more_q;
    rd_en     = 1'b0;
    rd_bank   = rbank_q;
    issue_idx = rd_idx_q;
    frames_d  = frames_q + 16'(rel_en);
    unique case (rstate_q)
      RIdle: begin
        if (|full_q) begin
          // With both banks full the older one is the bank not being written
          rd_bank   = (&full_q) ? ~wbank_q : full_q[1];
          rbank_d   = rd_bank;
          issue_idx = '0;
          rd_en     = 1'b1;
          rd_idx_d  = ADDR_W'(1);
          rd_more_d = 1'b1;
          rstate_d  = RStream;
        end
      end
      RStream: begin
        if (rd_more_q && space) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + ADDR_W'(1);
          if (rd_idx_q == IdxLast) rd_more_d = 1'b0;
        end
        if (rel_en) rstate_d = RIdle;
      end
      default: rstate_d = RIdle;
    endcase
    rd_addr        = {rd_bank, issue_idx};
    inflight_d     = rd_en;
    inflight_sof_d = rd_en & (issue_idx == '0);
    inflight_eof_d = rd_en & (issue_idx == IdxLast);
  end

  always_comb begin
    out_take     = ~out_valid_q | pop;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sof_d   = skid_sof_q;
    skid_eof_d   = skid_eof_q;
    if (out_take) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sof_d    = skid_sof_q;
        out_eof_d    = skid_eof_q;
        skid_valid_d = inflight_q;
        skid_data_d  = rd_data_q;
        skid_sof_d   = inflight_sof_q;
        skid_eof_d   = inflight_eof_q;
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_data_d  = rd_data_q;
        out_sof_d   = inflight_sof_q;
        out_eof_d   = inflight_eof_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rd_data_q;
      skid_sof_d   = inflight_sof_q;
      skid_eof_d   = inflight_eof_q;
    end
  end

  always_ff @(posedge clk_in or posedge switch_reset) begin
    if (switch_reset) begin
      wstate_q       <= WFill;
      wbank_q        <= 1'b0;
      widx_q         <= '0;
      full_q         <= '0;
      overflow_q     <= 1'b0;
      rstate_q       <= RIdle;
      rbank_q        <= 1'b0;
      rd_idx_q       <= '0;
      rd_more_q      <= 1'b0;
      frames_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_sof_q <= 1'b0;
      inflight_eof_q <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_data_q    <= '0;
      skid_sof_q     <= 1'b0;
      skid_eof_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sof_q      <= 1'b0;
      out_eof_q      <= 1'b0;
    end else begin
      wstate_q       <= wstate_d;
      wbank_q        <= wbank_d;
      widx_q         <= widx_d;
      full_q         <= full_d;
      overflow_q     <= overflow_d;
      rstate_q       <= rstate_d;
      rbank_q        <= rbank_d;
      rd_idx_q       <= rd_idx_d;
      rd_more_q      <= rd_more_d;
      frames_q       <= frames_d;
      inflight_q     <= inflight_d;
      inflight_sof_q <= inflight_sof_d;
      inflight_eof_q <= inflight_eof_d;
      skid_valid_q   <= skid_valid_d;
      skid_data_q    <= skid_data_d;
      skid_sof_q     <= skid_sof_d;
      skid_eof_q     <= skid_eof_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sof_q      <= out_sof_d;
      out_eof_q      <= out_eof_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_valid_q & out_sof_q;
  assign out_eof     = out_valid_q & out_eof_q;
  assign overflow    = overflow_q;
  assign frames_done = frames_q;

endmodule

// File: doc/pcm_frame_buffer.md
Name: pcm_frame_buffer

Overview:
- Sits directly downstream of the per-microphone CIC decimation stage.
- Captures the 16-bit decimated PCM samples, which arrive on a one-cycle valid strobe, into a ping-pong pair of frame banks.
- Each complete frame is streamed out with a valid/ready handshake to the array processing logic (beamformer / host transfer).
- Decouples the fixed-rate filter output from a back-pressured consumer and reports lost frames.

Parameters:
DATA_W, 16, sample width; matches the CIC output width.
FRAME_LEN, 64, samples per frame; power of two, minimum 4.
ADDR_W, 6, log2(FRAME_LEN); index width within one bank.

Ports:
clk_in  input  1  system clock; same clock that drives the CIC filter.
switch_reset  input  1  reset, asynchronous, active-high; clears all state.
pcm_in  input  DATA_W  sample from the CIC filter output, two's complement.
pcm_valid  input  1  one-cycle strobe, driven by the CIC out_valid; pcm_in is valid in that cycle.
out_data  output  DATA_W  frame sample to the consumer.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
out_sof  output  1  qualifies the first sample of a frame; valid only while out_valid.
out_eof  output  1  qualifies the last sample of a frame; valid only while out_valid.
overflow  output  1  sticky; set when any sample was dropped.
clr_overflow  input  1  synchronous clear of overflow.
frames_done  output  16  count of frames fully transferred; wraps at 65535 -> 0.

Behaviour:
- Reset (async, while switch_reset=1):
  - Both banks marked empty; write bank = 0; write index = 0; writer state W_FILL.
  - out_valid=0, out_sof=0, out_eof=0, out_data=0, overflow=0, frames_done=0.
  - Bank RAM contents are don't-care.
- Storage: 2*FRAME_LEN x DATA_W with synchronous read; address = {bank, index}. Must map to block RAM.
- Writer FSM:
  - W_FILL: on pcm_valid, write pcm_in at {wbank, widx} and increment widx.
    - When widx==FRAME_LEN-1 is written, mark wbank full and reset widx to 0.
    - If the other bank is empty (or is released in that same cycle), toggle wbank and stay in W_FILL.
    - Otherwise go to W_WAIT.
  - W_WAIT: every pcm_valid sample is dropped and sets overflow.
    - When the other bank is released, toggle wbank, widx=0, go to W_FILL. The first sample after the release starts the new frame; partial frames are never emitted.
- Reader FSM:
  - R_IDLE: when any bank is full, select it as rbank. If both are full, take the older one, i.e. the bank not equal to wbank. Issue read of index 0 and go to R_STREAM.
  - R_STREAM: present samples 0..FRAME_LEN-1 in order.
    - out_data, out_sof and out_eof are held stable while out_valid && !out_ready.
    - Sustained 1 sample/cycle while out_ready=1. Use a prefetch/skid register so RAM read latency causes no bubbles after the first word.
    - On acceptance of the eof word: release rbank (mark empty), increment frames_done, go to R_IDLE.
    - out_valid deasserts for at least one cycle between frames.
- Latency: first out_valid of a frame is asserted 2 cycles after the clk_in edge that writes that frame's last sample, when the reader is idle.
- Simultaneous events:
  - A write to the last index in the same cycle the reader releases the other bank gives a seamless switch, with no overflow.
  - clr_overflow coinciding with a drop leaves overflow=1 (set wins).
- Samples are never modified; no arithmetic on the data path. frames_done is a 16-bit unsigned wrap counter.
- out_ready toggling while out_valid=0 has no effect.

Test Plan:
1. FRAME_LEN=8; pcm_valid every 14 cycles with pcm_in ramp 0..7, out_ready=1 -> eight outputs 0..7, sof on 0, eof on 7, first out_valid 2 cycles after sample 7 is written, frames_done=1, overflow=0.
2. Continuous ramp 0..31, out_ready=1 -> four frames out in order (0..7, 8..15, 16..23, 24..31), frames_done=4, overflow=0.
3. out_ready=0 throughout, ramp 0..23 -> frames 0..7 and 8..15 held; samples 16..23 dropped, overflow=1. Then raise out_ready and send ramp 100..107 -> output 0..7, 8..15, 100..107.
4. Random out_ready (50% duty) during frame output -> out_data/out_sof/out_eof stable while stalled, no duplicated or missing samples, order intact.
5. Assert switch_reset asynchronously mid-frame (between clock edges) -> out_valid, overflow and frames_done go to 0 immediately. Next ramp 200..207 -> emitted as a clean frame with sof on 200.
6. With overflow=1, pulse clr_overflow in a cycle with no drop -> overflow=0 next cycle. Pulse it in a cycle with a drop -> overflow stays 1.
